// File: rtl/spi_bridge_mailbox.sv
// Register slave behind the SPI bridge: ID, control/status, scratch registers and a
// two-way mailbox to the fabric (inbound word FIFO, single outbound word register).
module spi_bridge_mailbox #(
    parameter int          RX_DEPTH_LOG2 = 4,
    parameter logic [31:0] ID_VALUE      = 32'h1D70_0001
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        avallon_read,
    input  logic        avallon_write,
    input  logic [31:0] address,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] write_data_to_avallon,
    output logic [31:0] read_data_from_avallon,
    output logic        acknowledge,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    output logic        uc_interrupt,
    output logic [1:0]  fsm_state
);

    localparam int               DEPTH      = 1 << RX_DEPTH_LOG2;
    localparam int               CNT_W      = RX_DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    localparam logic [3:0] OFF_ID       = 4'd0;
    localparam logic [3:0] OFF_STATUS   = 4'd1;
    localparam logic [3:0] OFF_CTRL     = 4'd2;
    localparam logic [3:0] OFF_RX       = 4'd3;
    localparam logic [3:0] OFF_TX       = 4'd4;
    localparam logic [3:0] OFF_SCRATCH0 = 4'd5;
    localparam logic [3:0] OFF_SCRATCH3 = 4'd8;

    // Bus handshake: the master holds read or write (plus address/data) until it sees
    // the single-cycle acknowledge, then must drop both before the next request is taken.
    // Outbound: a word moves on a cycle where tx_valid & tx_ready. Inbound: likewise with rx_*.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic        req_rd, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic [31:0] rdata_q, rdata_nxt;

    logic        irq_enable;
    logic [31:0] scratch [4];
    logic        rx_underflow, err, tx_overrun;

    logic [31:0]              rx_mem [DEPTH];
    logic [RX_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]         rx_count;
    logic                     rx_not_empty, rx_full;

    logic unused_addr_bits;
    assign unused_addr_bits = ^address[1:0];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (avallon_read || avallon_write) state_nxt = EXEC;
            EXEC:    state_nxt = ACK;
            ACK:     state_nxt = RELEASE;
            RELEASE: if (!avallon_read && !avallon_write) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        acknowledge            = (state == ACK);
        read_data_from_avallon = (state == ACK) ? rdata_q : 32'd0;
        fsm_state              = state;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
            req_addr  <= 32'd0;
            req_be    <= 4'd0;
            req_wdata <= 32'd0;
        end else if (state == IDLE && (avallon_read || avallon_write)) begin
            req_rd    <= avallon_read;
            req_wr    <= avallon_write;
            req_addr  <= address;
            req_be    <= byte_enable;
            req_wdata <= write_data_to_avallon;
        end
    end

    logic       exec, addr_ok, off_ok, acc_rd, acc_wr, bad_access;
    logic [3:0] off;
    logic [1:0] scr_idx;
    logic       rx_pop, rx_push, rx_under_set, rx_flush, sticky_clear, ctrl_wr;
    logic       tx_wr, tx_drop, tx_load, scr_wr;

    assign exec       = (state == EXEC);
    assign off        = req_addr[5:2];
    assign addr_ok    = (req_addr[31:6] == 26'd0);
    assign off_ok     = (off <= OFF_SCRATCH3);
    assign acc_rd     = exec & req_rd & ~req_wr & addr_ok & off_ok;
    assign acc_wr     = exec & req_wr & ~req_rd & addr_ok & off_ok;
    assign bad_access = exec & ((req_rd & req_wr) | ~addr_ok | ~off_ok);
    assign scr_idx    = 2'(off - OFF_SCRATCH0);

    assign rx_not_empty = (rx_count != '0);
    assign rx_full      = (rx_count == FULL_COUNT);
    assign rx_ready     = ~rx_full;

    assign rx_pop       = acc_rd & (off == OFF_RX) & rx_not_empty;
    assign rx_under_set = acc_rd & (off == OFF_RX) & ~rx_not_empty;
    assign ctrl_wr      = acc_wr & (off == OFF_CTRL) & req_be[0];
    assign rx_flush     = ctrl_wr & req_wdata[1];
    assign sticky_clear = ctrl_wr & req_wdata[2];
    assign tx_wr        = acc_wr & (off == OFF_TX);
    assign tx_drop      = tx_wr & tx_valid & ~tx_ready;
    assign tx_load      = tx_wr & ~tx_drop;
    assign scr_wr       = acc_wr & (off >= OFF_SCRATCH0);
    // A flush in the same cycle wins over an incoming fabric word.
    assign rx_push      = rx_valid & rx_ready & ~rx_flush;

    logic [31:0] tx_word;
    always_comb begin
        for (int i = 0; i < 4; i++)
            tx_word[8*i +: 8] = req_be[i] ? req_wdata[8*i +: 8] : 8'h00;
    end

    logic [31:0] status;
    logic [7:0]  count8;
    assign count8 = 8'(rx_count);
    assign status = {12'd0, tx_overrun, err, rx_underflow, tx_valid,
                     count8, 6'd0, rx_full, rx_not_empty};

    always_comb begin
        rdata_nxt = 32'd0;
        if (acc_rd) begin
            case (off)
                OFF_ID:     rdata_nxt = ID_VALUE;
                OFF_STATUS: rdata_nxt = status;
                OFF_CTRL:   rdata_nxt = {31'd0, irq_enable};
                OFF_RX:     rdata_nxt = rx_not_empty ? rx_mem[rd_ptr] : 32'd0;
                OFF_TX:     rdata_nxt = 32'd0;
                default:    rdata_nxt = scratch[scr_idx];
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)   rdata_q <= 32'd0;
        else if (exec) rdata_q <= rdata_nxt;
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else if (rx_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) wr_ptr <= wr_ptr + 1'b1;
            if (rx_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            irq_enable   <= 1'b0;
            rx_underflow <= 1'b0;
            err          <= 1'b0;
            tx_overrun   <= 1'b0;
            uc_interrupt <= 1'b0;
            tx_valid     <= 1'b0;
            tx_data      <= 32'd0;
            for (int i = 0; i < 4; i++) scratch[i] <= 32'd0;
        end else begin
            uc_interrupt <= irq_enable & rx_not_empty;
            if (ctrl_wr) irq_enable <= req_wdata[0];
            if (sticky_clear) begin
                rx_underflow <= 1'b0;
                err          <= 1'b0;
                tx_overrun   <= 1'b0;
            end else begin
                if (rx_under_set) rx_underflow <= 1'b1;
                if (bad_access)   err          <= 1'b1;
                if (tx_drop)      tx_overrun   <= 1'b1;
            end
            // A load in the same cycle as a fabric accept keeps the slot occupied.
            if (tx_load) begin
                tx_data  <= tx_word;
                tx_valid <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
            if (scr_wr) begin
                for (int i = 0; i < 4; i++)
                    if (req_be[i]) scratch[scr_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_spi_bridge_mailbox.sv
// Self-checking bench: transaction-level model of the register map and mailbox,
// compared against the DUT on every negative clock edge.
module tb_spi_bridge_mailbox;

    localparam int          DEPTH = 16;
    localparam logic [31:0] ID    = 32'h1D70_0001;

    logic        clk, nreset;
    logic        avallon_read, avallon_write;
    logic [31:0] address, write_data_to_avallon, read_data_from_avallon;
    logic [3:0]  byte_enable;
    logic        acknowledge;
    logic        rx_valid, rx_ready, tx_valid, tx_ready, uc_interrupt;
    logic [31:0] rx_data, tx_data;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int rx_mode = 0;
    int tx_mode = 0;

    // behavioural model state
    logic [31:0] m_q[$];
    bit          m_irq_en, m_und, m_err, m_ovr, m_txv, m_uc;
    logic [31:0] m_txd;
    logic [31:0] m_scr[4];
    logic [31:0] exp_q[$];
    bit          exp_v_q[$];

    int          acc_seq = 0;
    int          acc_done = 0;
    bit          a_rd, a_wr;
    logic [31:0] a_addr, a_wd;
    logic [3:0]  a_be;

    spi_bridge_mailbox dut (
        .clk                    (clk),
        .nreset                 (nreset),
        .avallon_read           (avallon_read),
        .avallon_write          (avallon_write),
        .address                (address),
        .byte_enable            (byte_enable),
        .write_data_to_avallon  (write_data_to_avallon),
        .read_data_from_avallon (read_data_from_avallon),
        .acknowledge            (acknowledge),
        .rx_valid               (rx_valid),
        .rx_data                (rx_data),
        .rx_ready               (rx_ready),
        .tx_valid               (tx_valid),
        .tx_data                (tx_data),
        .tx_ready               (tx_ready),
        .uc_interrupt           (uc_interrupt),
        .fsm_state              (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_status(input int sz);
        return {12'd0, m_ovr, m_err, m_und, m_txv, 8'(sz), 6'd0, sz == DEPTH, sz != 0};
    endfunction

    // Model: one step per rising edge, using the inputs the bench drove at the falling edge.
    always @(posedge clk or negedge nreset) begin
        int          sz, idx;
        bit          push_ok, tx_fire, tx_loaded, flush, next_uc;
        logic [31:0] rd_exp;
        if (!nreset) begin
            m_q.delete();
            m_irq_en = 0; m_und = 0; m_err = 0; m_ovr = 0; m_txv = 0; m_uc = 0;
            m_txd = 32'd0;
            for (int i = 0; i < 4; i++) m_scr[i] = 32'd0;
        end else begin
            sz        = m_q.size();
            next_uc   = m_irq_en && (sz != 0);
            push_ok   = rx_valid && (sz < DEPTH);
            tx_fire   = m_txv && tx_ready;
            tx_loaded = 0;
            flush     = 0;
            if (acc_seq != acc_done) begin
                acc_done = acc_seq;
                rd_exp   = 32'd0;
                idx      = int'(a_addr[5:2]);
                if ((a_rd && a_wr) || a_addr[31:6] != 26'd0 || idx > 8) begin
                    m_err = 1;
                end else if (idx == 0) begin
                    if (a_rd) rd_exp = ID;
                end else if (idx == 1) begin
                    if (a_rd) rd_exp = m_status(sz);
                end else if (idx == 2) begin
                    if (a_rd) rd_exp = {31'd0, m_irq_en};
                    else if (a_be[0]) begin
                        m_irq_en = a_wd[0];
                        flush    = a_wd[1];
                        if (a_wd[2]) begin m_und = 0; m_err = 0; m_ovr = 0; end
                    end
                end else if (idx == 3) begin
                    if (a_rd) begin
                        if (sz != 0) rd_exp = m_q.pop_front();
                        else m_und = 1;
                    end
                end else if (idx == 4) begin
                    if (a_wr) begin
                        if (m_txv && !tx_ready) m_ovr = 1;
                        else begin m_txd = merge(32'd0, a_wd, a_be); m_txv = 1; tx_loaded = 1; end
                    end
                end else begin
                    if (a_rd) rd_exp = m_scr[idx-5];
                    else m_scr[idx-5] = merge(m_scr[idx-5], a_wd, a_be);
                end
                exp_q.push_back(rd_exp);
                exp_v_q.push_back(a_rd);
            end
            if (flush) begin m_q.delete(); push_ok = 0; end
            if (push_ok) m_q.push_back(rx_data);
            if (tx_fire && !tx_loaded) m_txv = 0;
            m_uc = next_uc;
        end
    end

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        logic [31:0] e;
        bit          v;
        if (chk_en && nreset) begin
            chk("rx_ready", rx_ready, m_q.size() < DEPTH);
            chk("tx_valid", tx_valid, m_txv);
            chk("tx_data", tx_data, m_txd);
            chk("uc_interrupt", uc_interrupt, m_uc);
            if (acknowledge === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected actual=1 required=0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    v = exp_v_q.pop_front();
                    if (v) chk("read_data", read_data_from_avallon, e);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rx_mode != 0) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = $urandom;
        end else begin
            rx_valid = 1'b0;
        end
        tx_ready = (tx_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input int hold,
                          output logic [31:0] rdata);
        int lat;
        tick();
        avallon_read          = rd;
        avallon_write         = wr;
        address               = addr;
        byte_enable           = be;
        write_data_to_avallon = wd;
        tick();
        a_rd = rd; a_wr = wr; a_addr = addr; a_be = be; a_wd = wd;
        acc_seq++;
        lat   = 1;
        rdata = 32'd0;
        while (acknowledge !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        chk("ack_latency", lat, 2);
        if (acknowledge === 1'b1) rdata = read_data_from_avallon;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("ack_single_pulse", acknowledge, 1'b0);
        end
        chk("state_release", fsm_state, 2'd3);
        avallon_read  = 1'b0;
        avallon_write = 1'b0;
        tick();
        chk("state_idle", fsm_state, 2'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] addr, wd;
        int          r, k;

        nreset = 1'b0;
        avallon_read = 0; avallon_write = 0; address = 0; byte_enable = 0;
        write_data_to_avallon = 0; rx_valid = 0; rx_data = 0; tx_ready = 0;
        repeat (3) @(negedge clk);
        chk("reset_ack", acknowledge, 1'b0);
        chk("reset_rdata", read_data_from_avallon, 32'd0);
        chk("reset_rx_ready", rx_ready, 1'b1);
        chk("reset_tx_valid", tx_valid, 1'b0);
        chk("reset_tx_data", tx_data, 32'd0);
        chk("reset_irq", uc_interrupt, 1'b0);
        chk("reset_state", fsm_state, 2'd0);
        nreset = 1'b1;
        chk_en = 1;

        // ID read with the request held six cycles
        access(1, 0, 32'h00, 4'hF, 32'd0, 4, rd);
        chk("id_value", rd, 32'h1D70_0001);

        access(0, 1, 32'h14, 4'b0101, 32'hAABB_CCDD, 1, rd);
        access(1, 0, 32'h14, 4'h0, 32'd0, 1, rd);
        chk("scratch0_be", rd, 32'h00BB_00DD);

        // fill the inbound FIFO with interrupts enabled
        access(0, 1, 32'h08, 4'h1, 32'h1, 1, rd);
        for (int i = 0; i < 17; i++) begin
            tick();
            rx_valid = 1'b1;
            rx_data  = (i < 16) ? 32'(i) : 32'hDEAD_BEEF;
        end
        tick();
        chk("full_rx_ready", rx_ready, 1'b0);
        chk("full_irq", uc_interrupt, 1'b1);
        access(1, 0, 32'h04, 4'h0, 32'd0, 1, rd);
        chk("status_full", rd, 32'h0000_1003);

        for (int i = 0; i < 16; i++) begin
            access(1, 0, 32'h0C, 4'h0, 32'd0, 1, rd);
            chk("rx_order", rd, 32'(i));
        end
        chk("empty_irq", uc_interrupt, 1'b0);
        access(1, 0, 32'h0C, 4'h0, 32'd0, 1, rd);
        chk("rx_underflow_data", rd, 32'd0);
        access(1, 0, 32'h04, 4'h0, 32'd0, 1, rd);
        chk("status_underflow", rd, 32'h0002_0000);

        // outbound word and overrun
        access(0, 1, 32'h08, 4'hF, 32'h5, 1, rd);
        access(0, 1, 32'h10, 4'hF, 32'h1234_5678, 1, rd);
        chk("tx_valid_set", tx_valid, 1'b1);
        access(0, 1, 32'h10, 4'hF, 32'h9, 1, rd);
        chk("tx_data_kept", tx_data, 32'h1234_5678);
        access(1, 0, 32'h04, 4'h0, 32'd0, 1, rd);
        chk("status_overrun", rd, 32'h0009_0000);
        tick();
        tx_ready = 1'b1;
        tick();
        tick();
        chk("tx_valid_clear", tx_valid, 1'b0);

        // error accesses, then sticky clear
        access(1, 1, 32'h14, 4'hF, 32'hFFFF_FFFF, 1, rd);
        chk("both_rdata", rd, 32'd0);
        access(1, 0, 32'h3C, 4'h0, 32'd0, 1, rd);
        chk("bad_off_rdata", rd, 32'd0);
        access(1, 0, 32'h100, 4'h0, 32'd0, 1, rd);
        chk("high_addr_rdata", rd, 32'd0);
        access(1, 0, 32'h04, 4'h0, 32'd0, 1, rd);
        chk("status_err", rd, 32'h000C_0000);
        access(0, 1, 32'h08, 4'hF, 32'h4, 1, rd);
        access(1, 0, 32'h04, 4'h0, 32'd0, 1, rd);
        chk("status_cleared", rd, 32'd0);

        // randomized traffic against the model
        rx_mode = 1;
        tx_mode = 1;
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 16)      addr = 32'(r * 4) | 32'($urandom_range(0, 3));
            else if (r < 18) addr = (32'($urandom_range(1, 255)) << 6) | (32'($urandom_range(0, 15)) << 2);
            else             addr = 32'h0C;
            k  = int'($urandom_range(0, 9));
            wd = $urandom;
            if (addr[5:2] == 4'd2 && $urandom_range(0, 3) != 0) wd[1] = 1'b0;
            access(k <= 5, k == 0 || k >= 6, addr, 4'($urandom_range(0, 15)), wd,
                   int'($urandom_range(1, 3)), rd);
        end
        rx_mode = 0;
        tx_mode = 0;

        // reset in the middle of an acknowledged transaction
        access(0, 1, 32'h18, 4'hF, 32'hCAFE_F00D, 1, rd);
        access(0, 1, 32'h10, 4'hF, 32'h0000_0077, 1, rd);
        for (int i = 0; i < 3; i++) begin
            tick();
            rx_valid = 1'b1;
            rx_data  = 32'(100 + i);
        end
        tick();
        avallon_read = 1'b1;
        address      = 32'h00;
        tick();
        a_rd = 1; a_wr = 0; a_addr = 32'h00; a_be = 4'h0; a_wd = 32'd0;
        acc_seq++;
        tick();
        chk("ack_before_reset", acknowledge, 1'b1);
        #2 nreset = 1'b0;
        #1;
        chk("async_reset_ack", acknowledge, 1'b0);
        chk("async_reset_state", fsm_state, 2'd0);
        chk("async_reset_rdata", read_data_from_avallon, 32'd0);
        chk("async_reset_rx_ready", rx_ready, 1'b1);
        chk("async_reset_tx_valid", tx_valid, 1'b0);
        avallon_read = 1'b0;
        tick();
        tick();
        nreset = 1'b1;
        access(1, 0, 32'h18, 4'h0, 32'd0, 1, rd);
        chk("scratch1_after_reset", rd, 32'd0);
        access(1, 0, 32'h04, 4'h0, 32'd0, 1, rd);
        chk("status_after_reset", rd, 32'd0);
        access(1, 0, 32'h08, 4'h0, 32'd0, 1, rd);
        chk("ctrl_after_reset", rd, 32'd0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
